// File: rtl/pwm_capture.sv
// PWM period / high-time capture with APB register access.
// Optional interrupt output is built only when PWM_CAPTURE_IRQ_EN is defined.
module pwm_capture (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        PWMI,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t      state;
  logic        sync1, sync2, sync_d;
  logic        rise, fall;
  logic [31:0] cnt, hreg, capper, caphigh;
  logic        en, ie_done, ie_to;
  logic        done, ovr, to;
  logic        wr, sel_ctrl, sel_per, sel_high, sel_stat;
  logic        tmo, cap_evt;
  logic        unused;

  assign PREADY = 1'b1;
  assign wr     = PSEL & PENABLE & PWRITE & PREADY;

  // One-hot address decode; lower address bits take priority when several are set
  assign sel_ctrl = PADDR[2];
  assign sel_per  = ~PADDR[2] & PADDR[3];
  assign sel_high = ~PADDR[2] & ~PADDR[3] & PADDR[4];
  assign sel_stat = ~PADDR[2] & ~PADDR[3] & ~PADDR[4] & PADDR[5];

  assign unused = ^{PADDR[31:6], PADDR[1:0], PWDATA[31:3]};

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= PWMI;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync_d;
  assign fall = ~sync2 & sync_d;

  // Timeout takes precedence over an edge arriving on the same cycle
  assign tmo     = en && ((state == HIGH) || (state == LOW)) && (cnt == 32'hFFFF_FFFF);
  assign cap_evt = en && (state == LOW) && rise && !tmo;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      hreg    <= '0;
      capper  <= '0;
      caphigh <= '0;
    end else if (!en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: state <= ARM;
        ARM: begin
          if (rise) begin
            cnt   <= 32'd1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (tmo) begin
            cnt   <= '0;
            state <= ARM;
          end else begin
            cnt <= cnt + 32'd1;
            if (fall) begin
              hreg  <= cnt;
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (tmo) begin
            cnt   <= '0;
            state <= ARM;
          end else if (rise) begin
            capper  <= cnt;
            caphigh <= hreg;
            cnt     <= 32'd1;
            state   <= HIGH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en <= 1'b0;
    end else if (wr && sel_ctrl) begin
      en <= PWDATA[0];
    end
  end

  // Hardware set is OR-ed after the W1C mask so a same-cycle set wins
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      done <= 1'b0;
      ovr  <= 1'b0;
      to   <= 1'b0;
    end else begin
      done <= cap_evt | (done & ~(wr & sel_stat & PWDATA[0]));
      ovr  <= (cap_evt & done) | (ovr & ~(wr & sel_stat & PWDATA[1]));
      to   <= tmo | (to & ~(wr & sel_stat & PWDATA[2]));
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ie_done <= 1'b0;
      ie_to   <= 1'b0;
    end else if (wr && sel_ctrl) begin
      ie_done <= PWDATA[1];
      ie_to   <= PWDATA[2];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= (done & ie_done) | (to & ie_to);
    end
  end
`else
  assign ie_done = 1'b0;
  assign ie_to   = 1'b0;
  assign IRQ     = 1'b0;
`endif

  always_comb begin
    PRDATA = '0;
    if (sel_ctrl) begin
      PRDATA[2:0] = {ie_to, ie_done, en};
    end else if (sel_per) begin
      PRDATA = capper;
    end else if (sel_high) begin
      PRDATA = caphigh;
    end else if (sel_stat) begin
      PRDATA[2:0] = {to, ovr, done};
    end
  end

endmodule
